// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: mode encoding, sample-edge selection and
// the default word returned when no TX data is queued.
package spi_pkg;

   typedef enum logic [1:0] {
      MODE0 = 2'd0,
      MODE1 = 2'd1,
      MODE2 = 2'd2,
      MODE3 = 2'd3
   } spi_mode_e;

   localparam logic [31:0] IDLE_WORD_DEFAULT = 32'h0000_0041;

   // Modes 0 and 3 sample on rising SCK, modes 1 and 2 on falling SCK.
   function automatic logic sample_on_rise(input logic cpol, input logic cpha);
      spi_mode_e mode;
      mode = spi_mode_e'({cpol, cpha});
      case (mode)
         MODE0, MODE3: return 1'b1;
         default:      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin plus an edge-history
// flop producing single-cycle rise/fall pulses.
module spi_edge_sync
   import spi_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic hist_q, hist_d;

   always_comb begin
      meta_d = din;
      sync_d = meta_q;
      hist_d = sync_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         hist_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign level = sync_q;
   assign rise  = sync_q & ~hist_q;
   assign fall  = ~sync_q & hist_q;

endmodule

// File: rtl/spi_slave_stream.sv
// SPI slave with valid/ready word streams on the system-clock side, a single
// TX holding register, and overrun/underrun/abort event pulses.
module spi_slave_stream
   import spi_pkg::*;
#(
   parameter int                DATA_W      = 8,
   parameter int                CPOL        = 0,
   parameter int                CPHA        = 0,
   parameter int                LSB_FIRST   = 0,
   parameter logic [DATA_W-1:0] IDLE_WORD   = IDLE_WORD_DEFAULT[DATA_W-1:0],
   parameter int                FRAME_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   SCK,
   input  logic                   SSEL,
   input  logic                   MOSI,
   output logic                   MISO,
   output logic                   miso_oe,
   output logic [DATA_W-1:0]      rx_data,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   input  logic [DATA_W-1:0]      tx_data,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   output logic                   rx_overrun,
   output logic                   tx_underrun,
   output logic                   rx_abort,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic                   busy
);

   localparam int             BCW         = $clog2(DATA_W);
   localparam logic [BCW-1:0] LAST_BIT    = BCW'(DATA_W - 1);
   localparam logic           SAMPLE_RISE = sample_on_rise(CPOL != 0, CPHA != 0);

   logic sck_lvl, sck_rise, sck_fall;
   logic ssel_lvl, ssel_rise, ssel_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;
   logic mosi_edges_unused;

   spi_edge_sync #(.RST_VAL(CPOL != 0)) u_sck_sync (
      .clk(clk), .rst(rst), .din(SCK), .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
   spi_edge_sync #(.RST_VAL(1'b1)) u_ssel_sync (
      .clk(clk), .rst(rst), .din(SSEL), .level(ssel_lvl), .rise(ssel_rise), .fall(ssel_fall));
   spi_edge_sync #(.RST_VAL(1'b0)) u_mosi_sync (
      .clk(clk), .rst(rst), .din(MOSI), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

   // MOSI is sampled as a level; its edge pulses have no consumer.
   assign mosi_edges_unused = mosi_rise ^ mosi_fall;

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
      if (LSB_FIRST != 0) return {b, w[DATA_W-1:1]};
      else                return {w[DATA_W-2:0], b};
   endfunction

   function automatic logic lead_bit(input logic [DATA_W-1:0] w);
      if (LSB_FIRST != 0) return w[0];
      else                return w[DATA_W-1];
   endfunction

   logic [BCW-1:0]         bitcnt_q, bitcnt_d;
   logic [DATA_W-1:0]      rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic [DATA_W-1:0]      tx_sh_q, tx_sh_d, hold_q, hold_d;
   logic                   hold_vld_q, hold_vld_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                   rx_overrun_q, rx_overrun_d;
   logic                   tx_underrun_q, tx_underrun_d;
   logic                   rx_abort_q, rx_abort_d;
   logic                   ssel_act_s, sample_s, word_done_s, commit_s;
   logic [DATA_W-1:0]      src_s;
   logic                   miso_s;

   always_comb begin
      ssel_act_s    = ~ssel_lvl;
      sample_s      = ssel_act_s & (sck_rise | sck_fall) & (sck_lvl == SAMPLE_RISE);
      word_done_s   = sample_s & (bitcnt_q == LAST_BIT);
      commit_s      = sample_s & (bitcnt_q == {BCW{1'b0}});
      src_s         = hold_vld_q ? hold_q : IDLE_WORD;
      bitcnt_d      = bitcnt_q;
      rx_sh_d       = rx_sh_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = rx_valid_q;
      tx_sh_d       = tx_sh_q;
      hold_d        = hold_q;
      hold_vld_d    = hold_vld_q;
      frame_cnt_d   = frame_cnt_q;
      rx_overrun_d  = 1'b0;
      tx_underrun_d = 1'b0;
      rx_abort_d    = 1'b0;

      if (!ssel_act_s) begin
         bitcnt_d = {BCW{1'b0}};
      end else if (sample_s) begin
         bitcnt_d = (bitcnt_q == LAST_BIT) ? {BCW{1'b0}} : bitcnt_q + BCW'(1);
      end else begin
         bitcnt_d = bitcnt_q;
      end

      // Partial words are only discarded here; the shift register is simply overwritten later.
      rx_abort_d = ssel_rise & (bitcnt_q != {BCW{1'b0}});

      if (sample_s) begin
         rx_sh_d = shift_in(rx_sh_q, mosi_lvl);
      end else begin
         rx_sh_d = rx_sh_q;
      end

      if (word_done_s && (!rx_valid_q || rx_ready)) begin
         rx_data_d  = rx_sh_d;
         rx_valid_d = 1'b1;
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end else begin
         rx_valid_d = rx_valid_q;
      end
      rx_overrun_d = word_done_s & rx_valid_q & ~rx_ready;

      // The commit already advances one bit: bit 0 was shown combinationally before it.
      if (commit_s) begin
         tx_sh_d       = shift_in(src_s, 1'b0);
         tx_underrun_d = ~hold_vld_q;
      end else if (sample_s) begin
         tx_sh_d = shift_in(tx_sh_q, 1'b0);
      end else begin
         tx_sh_d = tx_sh_q;
      end

      if (tx_valid && !hold_vld_q) begin
         hold_d     = tx_data;
         hold_vld_d = 1'b1;
      end else if (commit_s) begin
         hold_vld_d = 1'b0;
      end else begin
         hold_vld_d = hold_vld_q;
      end

      if (ssel_fall) begin
         frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
      end else begin
         frame_cnt_d = frame_cnt_q;
      end

      if (bitcnt_q == {BCW{1'b0}}) begin
         miso_s = lead_bit(src_s);
      end else begin
         miso_s = lead_bit(tx_sh_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bitcnt_q      <= {BCW{1'b0}};
         rx_sh_q       <= {DATA_W{1'b0}};
         rx_data_q     <= {DATA_W{1'b0}};
         rx_valid_q    <= 1'b0;
         tx_sh_q       <= {DATA_W{1'b0}};
         hold_q        <= {DATA_W{1'b0}};
         hold_vld_q    <= 1'b0;
         frame_cnt_q   <= {FRAME_CNT_W{1'b0}};
         rx_overrun_q  <= 1'b0;
         tx_underrun_q <= 1'b0;
         rx_abort_q    <= 1'b0;
      end else begin
         bitcnt_q      <= bitcnt_d;
         rx_sh_q       <= rx_sh_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         tx_sh_q       <= tx_sh_d;
         hold_q        <= hold_d;
         hold_vld_q    <= hold_vld_d;
         frame_cnt_q   <= frame_cnt_d;
         rx_overrun_q  <= rx_overrun_d;
         tx_underrun_q <= tx_underrun_d;
         rx_abort_q    <= rx_abort_d;
      end
   end

   assign MISO        = miso_s;
   assign miso_oe     = ~ssel_lvl;
   assign busy        = ~ssel_lvl;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_ready    = ~hold_vld_q;
   assign rx_overrun  = rx_overrun_q;
   assign tx_underrun = tx_underrun_q;
   assign rx_abort    = rx_abort_q;
   assign frame_cnt   = frame_cnt_q;

endmodule
